gig_eth_tx_frame_buf: RTL and testbench

Store-and-forward transmit frame buffer sitting directly upstream of the gigabit MAC TX path. It accepts whole frames from a user write port, drops aborted or oversize frames, and presents only complete frames to the MAC client TX interface (`mac_tx_data` / `mac_tx_dvld` / `mac_tx_ack` / `mac_tx_underrun`). Because frames are stored complete before transmission starts, the MAC can never see an underrun.

---
 rtl/gig_eth_tx_frame_buf_pkg.sv | 26 ++
 rtl/gig_eth_sdp_ram.sv | 24 ++
 rtl/gig_eth_tx_frame_buf.sv | 153 +++++++++++++++
 tb/tb_gig_eth_tx_frame_buf.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gig_eth_tx_frame_buf_pkg.sv
// Shared definitions for the gigabit TX frame buffer: default frame limits,
// read/write FSM encodings and the 9-bit buffer word (data byte + eof flag).
package gig_eth_tx_frame_buf_pkg;

  localparam int MAX_FRAME_SIZE_STANDARD_DEF = 1522;
  localparam int MAX_FRAME_SIZE_JUMBO_DEF    = 9022;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_LOAD,
    RD_WAIT_ACK,
    RD_STREAM,
    RD_GAP
  } rd_state_t;

  typedef enum logic {
    WR_NORMAL,
    WR_DISCARD
  } wr_state_t;

  typedef struct packed {
    logic       eof;
    logic [7:0] dat;
  } buf_word_t;

endpackage

// File: rtl/gig_eth_sdp_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port, one clock.
// Read latency 1 cycle; rd_word holds its value while rd_en is low; no backpressure.
module gig_eth_sdp_ram
  import gig_eth_tx_frame_buf_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  buf_word_t         wr_word,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output buf_word_t         rd_word
);

  buf_word_t mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
    if (rd_en) rd_word <= mem[rd_addr];
  end

endmodule

// File: rtl/gig_eth_tx_frame_buf.sv
// Store-and-forward TX buffer: eof accepted at T gives mac_tx_dvld at T+2, then one byte/cycle after ack.
// wr_ready drops only when 2^ADDR_W bytes are held; aborted/oversize frames are dropped and counted.
module gig_eth_tx_frame_buf
  import gig_eth_tx_frame_buf_pkg::*;
#(
  parameter int MAX_FRAME_SIZE_STANDARD = MAX_FRAME_SIZE_STANDARD_DEF,
  parameter int MAX_FRAME_SIZE_JUMBO    = MAX_FRAME_SIZE_JUMBO_DEF,
  parameter int ADDR_W                  = 14
) (
  input  logic              tx_clk,
  input  logic              reset,
  input  logic              conf_tx_en,
  input  logic              conf_tx_jumbo_en,
  input  logic [7:0]        wr_data,
  input  logic              wr_vld,
  input  logic              wr_eof,
  input  logic              wr_abort,
  output logic              wr_ready,
  output logic [7:0]        mac_tx_data,
  output logic              mac_tx_dvld,
  input  logic              mac_tx_ack,
  output logic              mac_tx_underrun,
  output logic [ADDR_W-1:0] frames_queued,
  output logic [15:0]       drop_cnt
);

  localparam int PTR_W = ADDR_W + 1;

  if ((2 ** ADDR_W) < MAX_FRAME_SIZE_JUMBO) begin : g_depth_chk
    $error("ADDR_W too small to hold a MAX_FRAME_SIZE_JUMBO frame");
  end

  wr_state_t        wr_state;
  rd_state_t        rd_state;
  logic [PTR_W-1:0] wr_ptr, commit_ptr, rd_start_ptr, rd_ptr, ram_rd_ptr, used_bytes;
  logic [15:0]      frame_len, frame_limit;
  logic             wr_accept, wr_oversize, ram_wr_en, wr_commit, ram_rd_en;
  buf_word_t        ram_wr_word, rd_word;

  assign frame_limit = conf_tx_jumbo_en ? 16'(MAX_FRAME_SIZE_JUMBO) : 16'(MAX_FRAME_SIZE_STANDARD);
  assign used_bytes  = wr_ptr - rd_start_ptr;
  assign wr_ready    = (wr_state == WR_DISCARD) || (used_bytes < {1'b1, {ADDR_W{1'b0}}});
  assign wr_accept   = wr_vld && wr_ready;
  assign wr_oversize = frame_len >= frame_limit;
  assign ram_wr_en   = (wr_state == WR_NORMAL) && wr_accept && !wr_abort && !wr_oversize;
  assign wr_commit   = ram_wr_en && wr_eof;
  assign ram_wr_word = {wr_eof, wr_data};

  assign mac_tx_data     = mac_tx_dvld ? rd_word.dat : 8'h00;
  assign mac_tx_underrun = 1'b0;

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      wr_state   <= WR_NORMAL;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      frame_len  <= '0;
      drop_cnt   <= '0;
    end else if (wr_state == WR_DISCARD) begin
      if (wr_abort || (wr_vld && wr_eof)) wr_state <= WR_NORMAL;
    end else if (wr_abort || (wr_accept && wr_oversize)) begin
      wr_ptr    <= commit_ptr;
      frame_len <= '0;
      drop_cnt  <= drop_cnt + 1'b1;
      // An oversize byte that is itself the eof already ends the frame.
      if (!wr_abort && !wr_eof) wr_state <= WR_DISCARD;
    end else if (ram_wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (wr_eof) begin
        commit_ptr <= wr_ptr + 1'b1;
        frame_len  <= '0;
      end else begin
        frame_len <= frame_len + 1'b1;
      end
    end
  end

  // RAM output register is the look-ahead stage: its enable stalls byte 0 until ack.
  always_comb begin
    ram_rd_en  = 1'b0;
    ram_rd_ptr = rd_ptr;
    case (rd_state)
      RD_LOAD: begin
        ram_rd_en  = 1'b1;
        ram_rd_ptr = rd_start_ptr;
      end
      RD_WAIT_ACK: ram_rd_en = mac_tx_ack && !rd_word.eof;
      RD_STREAM:   ram_rd_en = !rd_word.eof;
      default:     ram_rd_en = 1'b0;
    endcase
  end

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      rd_state     <= RD_IDLE;
      rd_start_ptr <= '0;
      rd_ptr       <= '0;
      mac_tx_dvld  <= 1'b0;
    end else begin
      if (ram_rd_en) rd_ptr <= ram_rd_ptr + 1'b1;
      case (rd_state)
        RD_IDLE:
          if (conf_tx_en && (frames_queued != '0 || wr_commit)) rd_state <= RD_LOAD;
        RD_LOAD: begin
          rd_state    <= RD_WAIT_ACK;
          mac_tx_dvld <= 1'b1;
        end
        RD_WAIT_ACK:
          if (mac_tx_ack) begin
            if (rd_word.eof) begin
              rd_state    <= RD_GAP;
              mac_tx_dvld <= 1'b0;
            end else begin
              rd_state <= RD_STREAM;
            end
          end
        RD_STREAM:
          if (rd_word.eof) begin
            rd_state    <= RD_GAP;
            mac_tx_dvld <= 1'b0;
          end
        RD_GAP: begin
          rd_start_ptr <= rd_ptr;
          // frames_queued still counts the frame just sent.
          if (conf_tx_en && (frames_queued > ADDR_W'(1) || wr_commit)) rd_state <= RD_LOAD;
          else rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      frames_queued <= '0;
    end else if (wr_commit && rd_state != RD_GAP) begin
      frames_queued <= frames_queued + 1'b1;
    end else if (!wr_commit && rd_state == RD_GAP) begin
      frames_queued <= frames_queued - 1'b1;
    end
  end

  gig_eth_sdp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (tx_clk),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_word (ram_wr_word),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_ptr[ADDR_W-1:0]),
    .rd_word (rd_word)
  );

endmodule

// File: tb/tb_gig_eth_tx_frame_buf.sv
// Bench for gig_eth_tx_frame_buf: frame-level model (kept/dropped by length and abort rules)
// plus a MAC-side monitor that drives ack and checks every transmitted byte.
module tb_gig_eth_tx_frame_buf;
  localparam int ADDR_W = 14;

  logic              tx_clk = 1'b0;
  logic              reset = 1'b1;
  logic              conf_tx_en = 1'b1;
  logic              conf_tx_jumbo_en = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              wr_vld = 1'b0;
  logic              wr_eof = 1'b0;
  logic              wr_abort = 1'b0;
  logic              wr_ready;
  logic [7:0]        mac_tx_data;
  logic              mac_tx_dvld;
  logic              mac_tx_ack = 1'b0;
  logic              mac_tx_underrun;
  logic [ADDR_W-1:0] frames_queued;
  logic [15:0]       drop_cnt;

  gig_eth_tx_frame_buf dut (
    .tx_clk           (tx_clk),
    .reset            (reset),
    .conf_tx_en       (conf_tx_en),
    .conf_tx_jumbo_en (conf_tx_jumbo_en),
    .wr_data          (wr_data),
    .wr_vld           (wr_vld),
    .wr_eof           (wr_eof),
    .wr_abort         (wr_abort),
    .wr_ready         (wr_ready),
    .mac_tx_data      (mac_tx_data),
    .mac_tx_dvld      (mac_tx_dvld),
    .mac_tx_ack       (mac_tx_ack),
    .mac_tx_underrun  (mac_tx_underrun),
    .frames_queued    (frames_queued),
    .drop_cnt         (drop_cnt)
  );

  always #5 tx_clk = ~tx_clk;

  int cyc = 0;
  always @(posedge tx_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: frames expected at the MAC, in order, and expected drops.
  byte unsigned exp_bytes[$];
  int           exp_lens[$];
  int           exp_drops = 0;
  int           eof_cyc = 0;
  int           ack_delay = 0;
  bit           in_reset = 1'b1;

  typedef enum int {M_IDLE, M_WAIT, M_STREAM, M_SKIP} mon_t;
  mon_t         mon = M_IDLE;
  byte unsigned cur_frame[$];
  int cur_len = 0, cur_idx = 0, wait_cnt = 0, idle_cnt = 100, frames_seen = 0;
  int last_rise_cyc = 0, last_ack_cyc = 0, last_end_cyc = 0, last_gap = 0;

  // MAC-side monitor: drives ack and compares each presented byte with the model.
  always @(negedge tx_clk) begin
    if (in_reset) begin
      mon        = M_IDLE;
      mac_tx_ack = 1'b0;
      idle_cnt   = 100;
    end else begin
      mac_tx_ack = 1'b0;
      chk("underrun", mac_tx_underrun, 0);
      if (mon == M_SKIP && !mac_tx_dvld) mon = M_IDLE;
      if (mon == M_STREAM) begin
        if (cur_idx < cur_len) begin
          chk("dvld_stream", mac_tx_dvld, 1);
          chk("byte_stream", mac_tx_data, cur_frame[cur_idx]);
          cur_idx++;
        end else begin
          chk("dvld_after_eof", mac_tx_dvld, 0);
          last_end_cyc = cyc;
          frames_seen++;
          idle_cnt = 1;
          mon = M_IDLE;
        end
      end else if (mon == M_WAIT) begin
        chk("dvld_wait", mac_tx_dvld, 1);
        chk("byte0_hold", mac_tx_data, cur_frame[0]);
      end else if (mon == M_IDLE) begin
        if (mac_tx_dvld) begin
          if (exp_lens.size() == 0) begin
            chk("unexpected_frame", 1, 0);
            mon = M_SKIP;
          end else begin
            cur_len = exp_lens.pop_front();
            cur_frame.delete();
            for (int i = 0; i < cur_len; i++) cur_frame.push_back(exp_bytes.pop_front());
            chk("frame_gap_ge2", idle_cnt >= 2, 1);
            last_gap = idle_cnt;
            last_rise_cyc = cyc;
            chk("byte0", mac_tx_data, cur_frame[0]);
            wait_cnt = 0;
            mon = M_WAIT;
          end
        end else begin
          idle_cnt++;
        end
      end
      if (mon == M_WAIT) begin
        if (wait_cnt >= ack_delay) begin
          mac_tx_ack = 1'b1;
          last_ack_cyc = cyc;
          cur_idx = 1;
          mon = M_STREAM;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Drive one frame; abort_at >= 0 raises wr_abort with that byte and ends the frame there.
  task automatic send_frame(input int len, input int abort_at, input bit gaps);
    byte unsigned fb[$];
    int limit;
    int t;
    limit = conf_tx_jumbo_en ? 9022 : 1522;
    for (int i = 0; i < len; i++) begin
      byte unsigned d;
      d = 8'($urandom);
      while (gaps && $urandom_range(7) == 0) begin
        @(negedge tx_clk);
        wr_vld = 1'b0; wr_eof = 1'b0; wr_abort = 1'b0;
      end
      @(negedge tx_clk);
      t = 0;
      while (!wr_ready && t < 2000) begin
        wr_vld = 1'b0;
        @(negedge tx_clk);
        t++;
      end
      if (t >= 2000) chk("wr_ready_timeout", 0, 1);
      wr_vld   = 1'b1;
      wr_data  = d;
      wr_eof   = (i == len - 1);
      wr_abort = (i == abort_at);
      if (i == len - 1) eof_cyc = cyc;
      fb.push_back(d);
      if (i == abort_at) break;
    end
    @(negedge tx_clk);
    wr_vld = 1'b0; wr_eof = 1'b0; wr_abort = 1'b0;
    if ((abort_at >= 0 && abort_at < len) || len > limit) begin
      exp_drops++;
    end else begin
      foreach (fb[i]) exp_bytes.push_back(fb[i]);
      exp_lens.push_back(len);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_lens.size() != 0 || mon != M_IDLE) && n < 30000) begin
      @(negedge tx_clk);
      n++;
    end
    if (n >= 30000) chk("drain_timeout", 0, 1);
    repeat (4) @(negedge tx_clk);
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen0, len, ab;
    repeat (3) @(negedge tx_clk);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_dvld", mac_tx_dvld, 0);
    chk("rst_data", mac_tx_data, 0);
    chk("rst_underrun", mac_tx_underrun, 0);
    chk("rst_frames_queued", frames_queued, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    reset = 1'b0;
    in_reset = 1'b0;
    repeat (2) @(negedge tx_clk);

    // 64-byte frame, ack on first dvld cycle
    ack_delay = 0;
    send_frame(64, -1, 1'b0);
    chk("t1_fq_after_eof", frames_queued, 1);
    wait_drain();
    chk("t1_eof_to_dvld", last_rise_cyc - eof_cyc, 2);
    chk("t1_ack_to_dvld_low", last_end_cyc - last_ack_cyc, 64);
    chk("t1_fq_final", frames_queued, 0);
    chk("t1_frames_seen", frames_seen, 1);

    // Ack delayed by 5 cycles
    ack_delay = 5;
    send_frame(40, -1, 1'b1);
    wait_drain();
    chk("t2_ack_delay", last_ack_cyc - last_rise_cyc, 5);
    chk("t2_frames_seen", frames_seen, 2);

    // Frame length limits
    ack_delay = 1;
    conf_tx_jumbo_en = 1'b0;
    send_frame(1523, -1, 1'b1);
    send_frame(60, -1, 1'b1);
    wait_drain();
    chk("t3_drop_std", drop_cnt, 1);
    chk("t3_frames_std", frames_seen, 3);
    send_frame(1522, -1, 1'b0);
    send_frame(1600, -1, 1'b1);
    send_frame(30, -1, 1'b1);
    wait_drain();
    chk("t3_drop_discard", drop_cnt, 2);
    chk("t3_frames_boundary", frames_seen, 5);
    conf_tx_jumbo_en = 1'b1;
    send_frame(1523, -1, 1'b0);
    wait_drain();
    chk("t3_frames_jumbo", frames_seen, 6);
    chk("t3_drop_jumbo", drop_cnt, exp_drops);

    // Aborts: mid-frame and coincident with eof
    send_frame(64, 30, 1'b1);
    send_frame(20, 19, 1'b1);
    repeat (20) @(negedge tx_clk);
    wait_drain();
    chk("t4_drop_abort", drop_cnt, 4);
    chk("t4_frames_none", frames_seen, 6);
    chk("t4_fq", frames_queued, 0);

    // Three 1-byte frames queued while TX is disabled
    ack_delay = 0;
    conf_tx_en = 1'b0;
    seen0 = frames_seen;
    repeat (3) send_frame(1, -1, 1'b1);
    repeat (10) @(negedge tx_clk);
    chk("t5_fq_held", frames_queued, 3);
    chk("t5_nothing_sent", frames_seen, seen0);
    conf_tx_en = 1'b1;
    wait_drain();
    chk("t5_frames_sent", frames_seen, seen0 + 3);
    chk("t5_min_gap", last_gap, 2);
    chk("t5_fq_final", frames_queued, 0);

    // Reset in the middle of streaming
    send_frame(200, -1, 1'b0);
    n = 0;
    while (!(mon == M_STREAM && cur_idx > 20) && n < 2000) begin
      @(negedge tx_clk);
      n++;
    end
    chk("t6_reached_stream", n < 2000, 1);
    #2;
    reset = 1'b1;
    in_reset = 1'b1;
    exp_bytes.delete();
    exp_lens.delete();
    exp_drops = 0;
    #1;
    chk("t6_dvld_drop", mac_tx_dvld, 0);
    chk("t6_fq_clear", frames_queued, 0);
    chk("t6_drop_clear", drop_cnt, 0);
    chk("t6_wr_ready", wr_ready, 1);
    repeat (3) @(negedge tx_clk);
    reset = 1'b0;
    in_reset = 1'b0;
    seen0 = frames_seen;
    send_frame(50, -1, 1'b1);
    wait_drain();
    chk("t6_frame_after_reset", frames_seen, seen0 + 1);
    chk("t6_drop_after_reset", drop_cnt, 0);

    // Random frames written while earlier ones are still transmitting
    seen0 = frames_seen;
    n = 0;
    for (int k = 0; k < 14; k++) begin
      conf_tx_jumbo_en = 1'($urandom_range(1));
      ack_delay = $urandom_range(3);
      len = $urandom_range(90, 1);
      ab = ($urandom_range(4) == 0) ? $urandom_range(len - 1, 0) : -1;
      if (ab < 0) n++;
      send_frame(len, ab, 1'b1);
    end
    wait_drain();
    chk("t7_frames", frames_seen, seen0 + n);
    chk("t7_drops", drop_cnt, exp_drops);
    chk("t7_fq_final", frames_queued, 0);
    chk("t7_wr_ready", wr_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
